// File: rtl/inst_ram_resp.sv
// Instruction RAM responder: 1-cycle registered fetch port plus a byte-serial loader.
// Optional INST_RAM_ERR_EN adds inst_ram_err (out-of-range or misaligned fetch flag).
//
//   state  | meaning
//   IDLE   | fetches served from memory, waiting for ld_start
//   LOAD   | accepting bytes, packing little-endian words into memory
//   DONE   | one-cycle ld_done pulse, fetches still blocked
module inst_ram_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ram_ren,
  input  logic [31:0] inst_ram_raddr,
  output logic [31:0] inst_ram_rdata,
`ifdef INST_RAM_ERR_EN
  output logic        inst_ram_err,
`endif
  input  logic        ld_start,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_done,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         word_fill;
  logic                mem_we;
  logic                accept;

  logic [31:0]         mem [DEPTH];

  logic [31:0]         rd_off;
  logic [ADDR_W-1:0]   rd_idx;
  logic                rd_in_range;
  logic                unused_off_lsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      waddr_q    <= '0;
      asm_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      waddr_q    <= waddr_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    waddr_d    = waddr_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
    ld_ready   = 1'b0;
    ld_done    = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    // Word as it would look with the incoming byte merged into its lane.
    word_fill  = asm_q;
    word_fill[{byte_cnt_q, 3'b000} +: 8] = ld_byte;

    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          byte_cnt_d = 2'd0;
          waddr_d    = '0;
          asm_d      = 32'd0;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        accept   = ld_valid;
        if (accept) begin
          if (ld_last || (byte_cnt_q == 2'd3)) begin
            mem_we     = 1'b1;
            asm_d      = 32'd0;
            byte_cnt_d = 2'd0;
            if (byte_cnt_q == 2'd3) begin
              waddr_d = waddr_q + 1'b1;
            end
            if (ld_last) begin
              state_d = S_DONE;
            end
          end else begin
            asm_d      = word_fill;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        ld_done = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Storage is deliberately not reset so a reset mid-run keeps the loaded program.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= word_fill;
    end
  end

  assign rd_off         = inst_ram_raddr - BASE_ADDR;
  assign rd_idx         = rd_off[ADDR_W+1:2];
  assign rd_in_range    = ((rd_off >> (ADDR_W + 2)) == 32'd0);
  assign unused_off_lsb = ^rd_off[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_ram_rdata <= NOP_INST;
    end else if (inst_ram_ren) begin
      if (busy || !rd_in_range) begin
        inst_ram_rdata <= NOP_INST;
      end else begin
        inst_ram_rdata <= mem[rd_idx];
      end
    end
  end

`ifdef INST_RAM_ERR_EN
  // A load-blocked fetch is not an addressing fault, so it reports no error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_ram_err <= 1'b0;
    end else if (inst_ram_ren) begin
      if (busy) begin
        inst_ram_err <= 1'b0;
      end else begin
        inst_ram_err <= !rd_in_range || (inst_ram_raddr[1:0] != 2'b00);
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_ram_resp.sv
// Self-checking bench for inst_ram_resp: loader sessions, fetch timing, hold, blocking, reset.
// Build with INST_RAM_ERR_EN defined to also check inst_ram_err.
module tb_inst_ram_resp;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        inst_ram_ren;
  logic [31:0] inst_ram_raddr;
  logic [31:0] inst_ram_rdata;
`ifdef INST_RAM_ERR_EN
  logic        inst_ram_err;
`endif
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_done;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  logic [31:0] model_mem [DEPTH];
  logic [31:0] m_asm;
  int          m_cnt;
  int          m_waddr;

  inst_ram_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_ram_ren   (inst_ram_ren),
    .inst_ram_raddr (inst_ram_raddr),
    .inst_ram_rdata (inst_ram_rdata),
`ifdef INST_RAM_ERR_EN
    .inst_ram_err   (inst_ram_err),
`endif
    .ld_start       (ld_start),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_byte        (ld_byte),
    .ld_last        (ld_last),
    .ld_done        (ld_done),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ld_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic ee, input string nm);
    logic [31:0] want;
    logic        want_err;
    inst_ram_ren   = 1'b1;
    inst_ram_raddr = a;
    exp_q.push_back(e);
    exp_err_q.push_back(ee);
    @(posedge clk); #1;
    inst_ram_ren = 1'b0;
    want     = exp_q.pop_front();
    want_err = exp_err_q.pop_front();
    total++;
    if (inst_ram_rdata !== want) begin
      bad++;
      $display("FAIL %s: rdata got=%h exp=%h", nm, inst_ram_rdata, want);
    end
`ifdef INST_RAM_ERR_EN
    total++;
    if (inst_ram_err !== want_err) begin
      bad++;
      $display("FAIL %s: err got=%b exp=%b", nm, inst_ram_err, want_err);
    end
`endif
    @(negedge clk);
  endtask

  task automatic start_session();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    total++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_session: busy=%b ld_ready=%b exp 1/1", busy, ld_ready);
    end
    m_asm = 32'd0; m_cnt = 0; m_waddr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int gap, input bit poke_start);
    int guard;
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      ld_start = poke_start && (g == 0);
      @(negedge clk);
    end
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    guard = 0;
    while (ld_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL send_byte timeout: ld_ready got=%b exp=1", ld_ready);
      ld_valid = 1'b0; ld_last = 1'b0;
      return;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    m_asm[8*m_cnt +: 8] = b;
    if (last || m_cnt == 3) begin
      model_mem[m_waddr] = m_asm;
      if (m_cnt == 3) m_waddr = (m_waddr + 1) % DEPTH;
      m_asm = 32'd0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (last) begin
      total++;
      if (ld_ready !== 1'b0 || ld_done !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL done_state: ready=%b done=%b busy=%b exp 0/1/1", ld_ready, ld_done, busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || ld_done !== 1'b0) begin
        bad++;
        $display("FAIL after_done: busy=%b done=%b exp 0/0", busy, ld_done);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (inst_ram_rdata !== NOP || ld_ready !== 1'b0 || ld_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdata=%h ready=%b done=%b busy=%b", inst_ram_rdata, ld_ready, ld_done, busy);
    end
`ifdef INST_RAM_ERR_EN
    total++;
    if (inst_ram_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got=%b exp=0", inst_ram_err);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    logic [7:0] bs [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int d0;
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < 8; i++) send_byte(bs[i], i == 7, 0, 1'b0);
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL load_basic done pulses: got=%0d exp=1", done_cnt - d0);
    end
    rd(32'd4, 32'h0010_0093, 1'b0, "first_fetch_w1");
    rd(32'd0, 32'h0000_0013, 1'b0, "b2b_fetch_w0");
  endtask

  task automatic test_hold();
    rd(32'd4, 32'h0010_0093, 1'b0, "hold_setup");
    for (int i = 0; i < 5; i++) begin
      inst_ram_raddr = $urandom;
      @(posedge clk); #1;
      total++;
      if (inst_ram_rdata !== 32'h0010_0093) begin
        bad++;
        $display("FAIL hold cycle %0d: rdata got=%h exp=00100093", i, inst_ram_rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_partial_load();
    logic [7:0] bs [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    start_session();
    for (int i = 0; i < 5; i++) send_byte(bs[i], i == 4, 0, 1'b0);
    rd(32'd0, 32'hDDCC_BBAA, 1'b0, "partial_w0");
    rd(32'd4, 32'h0000_0011, 1'b0, "partial_w1");
  endtask

  task automatic test_blocked();
    start_session();
    rd(32'd0, NOP, 1'b0, "busy_read");
    send_byte(8'h55, 1'b1, 1, 1'b0);
    rd(32'(4 * DEPTH), NOP, 1'b1, "out_of_range");
    rd(32'hFFFF_FFFC, NOP, 1'b1, "out_of_range_top");
    rd(32'd6, 32'h0000_0011, 1'b1, "misaligned");
    rd(32'd0, 32'h0000_0055, 1'b0, "single_byte_word");
  endtask

  task automatic test_reset_mid();
    start_session();
    send_byte(8'hEE, 1'b0, 0, 1'b0);
    send_byte(8'hFF, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || ld_ready !== 1'b0 || inst_ram_rdata !== NOP) begin
      bad++;
      $display("FAIL reset_mid: busy=%b ready=%b rdata=%h exp 0/0/%h", busy, ld_ready, inst_ram_rdata, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'd0, model_mem[0], 1'b0, "kept_w0");
    rd(32'd4, model_mem[1], 1'b0, "kept_w1");
  endtask

  task automatic test_random_gaps();
    int d0;
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom), i == 11, (i == 5) ? 2 : int'($urandom_range(0, 3)), i == 5);
    end
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL random_session: busy=%b done pulses=%0d exp 0/1", busy, done_cnt - d0);
    end
    for (int w = 0; w < 3; w++) rd(32'(4 * w), model_mem[w], 1'b0, "random_word");
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ram_ren = 1'b0;
    inst_ram_raddr = 32'd0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte = 8'd0;
    ld_last = 1'b0;
    test_reset();
    test_load_basic();
    test_hold();
    test_partial_load();
    test_blocked();
    test_reset_mid();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
